// File: rtl/char_sweep_seq.sv
// Sequencer for the dynamic-power characterization bench: walks slope x capacitance x pin x edge,
// captures one energy word per transition. Define SWEEP_ABORT_EN to add an abort input.
module char_sweep_seq #(
  parameter int unsigned NBSLOPES    = 7,
  parameter int unsigned NBCAPA      = 7,
  parameter int unsigned NB_PINS     = 2,
  parameter int unsigned TICK_CYCLES = 7,
  parameter int unsigned DATA_W      = 32,
  localparam int unsigned SW = (NBSLOPES > 1) ? $clog2(NBSLOPES) : 1,
  localparam int unsigned CW = (NBCAPA > 1) ? $clog2(NBCAPA) : 1,
  localparam int unsigned PW = (NB_PINS > 1) ? $clog2(NB_PINS) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
`ifdef SWEEP_ABORT_EN
  input  logic               abort,
`endif
  output logic [SW-1:0]      slope_idx,
  output logic [CW-1:0]      capa_idx,
  output logic [NB_PINS-1:0] din,
  input  logic [DATA_W-1:0]  meas_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [SW-1:0]      res_slope,
  output logic [CW-1:0]      res_capa,
  output logic [PW-1:0]      res_pin,
  output logic               res_rise,
  output logic               busy,
  output logic               done
);

  localparam int unsigned TW = $clog2(TICK_CYCLES + 1);
  localparam logic [SW-1:0] SLOPE_LAST = SW'(NBSLOPES - 1);
  localparam logic [CW-1:0] CAPA_LAST  = CW'(NBCAPA - 1);
  localparam logic [PW-1:0] PIN_LAST   = PW'(NB_PINS - 1);
  localparam logic [TW-1:0] SETTLE_END = TW'(TICK_CYCLES);
  localparam logic [TW-1:0] DRIVE_END  = TW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DRIVE,
    S_EMIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       slope_q, slope_d;
  logic [CW-1:0]       capa_q, capa_d;
  logic [PW-1:0]       pin_q, pin_d;
  logic                rise_q, rise_d;
  logic [NB_PINS-1:0]  din_q, din_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [SW-1:0]       res_slope_q, res_slope_d;
  logic [CW-1:0]       res_capa_q, res_capa_d;
  logic [PW-1:0]       res_pin_q, res_pin_d;
  logic                res_rise_q, res_rise_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PW-1:0]       pin_nxt;

  // Drive level for the toggled pin; every other input rests high.
  function automatic logic [NB_PINS-1:0] drive_pat(input logic [PW-1:0] pin, input logic rise);
    logic [NB_PINS-1:0] pat;
    pat      = '1;
    pat[pin] = rise;
    return pat;
  endfunction

  assign pin_nxt = pin_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    slope_d     = slope_q;
    capa_d      = capa_q;
    pin_d       = pin_q;
    rise_d      = rise_q;
    din_d       = din_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_slope_d = res_slope_q;
    res_capa_d  = res_capa_q;
    res_pin_d   = res_pin_q;
    res_rise_d  = res_rise_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        din_d  = '1;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_SETTLE;
          busy_d  = 1'b1;
          slope_d = '0;
          capa_d  = '0;
          pin_d   = '0;
          rise_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_END) begin
          state_d = S_DRIVE;
          din_d   = drive_pat(pin_q, rise_q);
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DRIVE: begin
        if (cnt_q == DRIVE_END) begin
          state_d     = S_EMIT;
          res_valid_d = 1'b1;
          res_data_d  = meas_in;
          res_slope_d = slope_q;
          res_capa_d  = capa_q;
          res_pin_d   = pin_q;
          res_rise_d  = rise_q;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_EMIT: begin
        // Advance order: edge, then pin, then capacitance, then slope.
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!rise_q) begin
            state_d = S_DRIVE;
            rise_d  = 1'b1;
            din_d   = drive_pat(pin_q, 1'b1);
          end else if (pin_q != PIN_LAST) begin
            state_d = S_DRIVE;
            pin_d   = pin_nxt;
            rise_d  = 1'b0;
            din_d   = drive_pat(pin_nxt, 1'b0);
          end else begin
            pin_d  = '0;
            rise_d = 1'b0;
            din_d  = '1;
            if (capa_q != CAPA_LAST) begin
              state_d = S_SETTLE;
              capa_d  = capa_q + CW'(1);
            end else if (slope_q != SLOPE_LAST) begin
              state_d = S_SETTLE;
              capa_d  = '0;
              slope_d = slope_q + SW'(1);
            end else begin
              state_d = S_DONE;
              slope_d = '0;
              capa_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SWEEP_ABORT_EN
    // DONE already returns to IDLE with its own done pulse, so abort only cuts an active sweep.
    if (abort && (state_q == S_SETTLE || state_q == S_DRIVE || state_q == S_EMIT)) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      slope_d     = '0;
      capa_d      = '0;
      pin_d       = '0;
      rise_d      = 1'b0;
      din_d       = '1;
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      slope_q     <= '0;
      capa_q      <= '0;
      pin_q       <= '0;
      rise_q      <= 1'b0;
      din_q       <= '1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_slope_q <= '0;
      res_capa_q  <= '0;
      res_pin_q   <= '0;
      res_rise_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slope_q     <= slope_d;
      capa_q      <= capa_d;
      pin_q       <= pin_d;
      rise_q      <= rise_d;
      din_q       <= din_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_slope_q <= res_slope_d;
      res_capa_q  <= res_capa_d;
      res_pin_q   <= res_pin_d;
      res_rise_q  <= res_rise_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign slope_idx = slope_q;
  assign capa_idx  = capa_q;
  assign din       = din_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_slope = res_slope_q;
  assign res_capa  = res_capa_q;
  assign res_pin   = res_pin_q;
  assign res_rise  = res_rise_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_char_sweep_seq.sv
// Bench for char_sweep_seq: event-time reference model plus literal latency/backpressure/reset checks.
module tb_char_sweep_seq;
  localparam int NS    = 7;
  localparam int NC    = 7;
  localparam int NP    = 2;
  localparam int T     = 7;
  localparam int DW    = 32;
  localparam int TOTAL = NS * NC * NP * 2;

  logic          clk       = 1'b0;
  logic          nrst      = 1'b0;
  logic          start     = 1'b0;
  logic          res_ready = 1'b0;
  logic [DW-1:0] meas_in   = '0;
`ifdef SWEEP_ABORT_EN
  logic          abort     = 1'b0;
`endif
  logic [2:0]    slope_idx, capa_idx, res_slope, res_capa;
  logic [NP-1:0] din;
  logic          res_valid, res_pin, res_rise, busy, done;
  logic [DW-1:0] res_data;

  char_sweep_seq #(
    .NBSLOPES(NS), .NBCAPA(NC), .NB_PINS(NP), .TICK_CYCLES(T), .DATA_W(DW)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start),
`ifdef SWEEP_ABORT_EN
    .abort(abort),
`endif
    .slope_idx(slope_idx), .capa_idx(capa_idx), .din(din), .meas_in(meas_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_slope(res_slope), .res_capa(res_capa), .res_pin(res_pin), .res_rise(res_rise),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: item i of the sweep plus the cycle its result becomes visible.
  int            cyc        = 0;
  bit            m_active   = 1'b0;
  int            m_idx      = 0;
  int            m_valid_at = 0;
  int            m_done_at  = -100;
  logic [DW-1:0] m_data     = '0;

  function automatic int it_slope(input int i); return i / (NC * NP * 2); endfunction
  function automatic int it_capa(input int i);  return (i / (NP * 2)) % NC; endfunction
  function automatic int it_pin(input int i);   return (i / 2) % NP;        endfunction
  function automatic int it_rise(input int i);  return i % 2;               endfunction

  // cyc counts edges since reset release; values seen after edge n are checked while cyc == n.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cyc        <= 0;
      m_active   <= 1'b0;
      m_idx      <= 0;
      m_valid_at <= 0;
      m_done_at  <= -100;
      m_data     <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!m_active) begin
        if (start && cyc != m_done_at) begin
          m_active   <= 1'b1;
          m_idx      <= 0;
          m_valid_at <= cyc + 2 * T + 2;
        end
      end
`ifdef SWEEP_ABORT_EN
      else if (abort) begin
        m_active  <= 1'b0;
        m_done_at <= cyc + 1;
      end
`endif
      else begin
        if (cyc + 1 == m_valid_at) m_data <= meas_in;
        if (cyc >= m_valid_at && res_ready) begin
          if (m_idx == TOTAL - 1) begin
            m_active  <= 1'b0;
            m_done_at <= cyc + 1;
          end else begin
            m_idx      <= m_idx + 1;
            m_valid_at <= cyc + 1 + ((((m_idx + 1) % (2 * NP)) == 0) ? 2 * T + 1 : T);
          end
        end
      end
    end
  end

  function automatic logic [NP-1:0] exp_din();
    logic [NP-1:0] d;
    d = '1;
    if (m_active && it_rise(m_idx) == 0 && cyc >= m_valid_at - T) d[it_pin(m_idx)] = 1'b0;
    return d;
  endfunction

  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_active));
    check("done", 64'(done), 64'(cyc == m_done_at));
    check("res_valid", 64'(res_valid), 64'(m_active && cyc >= m_valid_at));
    check("din", 64'(din), 64'(exp_din()));
    check("slope_idx", 64'(slope_idx), m_active ? 64'(it_slope(m_idx)) : 64'd0);
    check("capa_idx", 64'(capa_idx), m_active ? 64'(it_capa(m_idx)) : 64'd0);
    if (m_active && cyc >= m_valid_at) begin
      check("res_data", 64'(res_data), 64'(m_data));
      check("res_slope", 64'(res_slope), 64'(it_slope(m_idx)));
      check("res_capa", 64'(res_capa), 64'(it_capa(m_idx)));
      check("res_pin", 64'(res_pin), 64'(it_pin(m_idx)));
      check("res_rise", 64'(res_rise), 64'(it_rise(m_idx)));
    end
  end

  // Result log taken straight from the DUT handshakes.
  int         n_res  = 0;
  int         n_done = 0;
  logic [7:0] tag_log [0:1023];

  always @(posedge clk) begin
    if (nrst && res_valid && res_ready) begin
      if (n_res < 1024) tag_log[n_res[9:0]] <= {res_slope, res_capa, res_pin, res_rise};
      n_res <= n_res + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  bit use_rand   = 1'b0;
  bit rand_ready = 1'b0;
  bit rand_start = 1'b0;

  task automatic tick();
    @(negedge clk);
    meas_in = use_rand ? DW'($urandom) : DW'(cyc);
    if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
    if (rand_start) start = ($urandom_range(0, 50) == 0);
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 1000) begin
      tick();
      g++;
    end
    check("wait_cyc", 64'(cyc), 64'(n));
  endtask

  task automatic wait_done(input int budget, input string name);
    int g;
    g = 0;
    while (!done && g < budget) begin
      tick();
      g++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  int base, dbase, g;

  initial begin
    repeat (3) tick();
    check("rst_din", 64'(din), 64'd3);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_tags", 64'({res_slope, res_capa, res_pin, res_rise}), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    nrst = 1'b1;

    // Latency and first-result backpressure with meas_in = cycle count.
    base  = n_res;
    dbase = n_done;
    wait_cyc(9);
    start = 1'b1;
    wait_cyc(10);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    wait_cyc(17);
    check("din_before_drive", 64'(din), 64'd3);
    wait_cyc(18);
    check("din_first_fall", 64'(din), 64'd2);
    wait_cyc(24);
    check("valid_before", 64'(res_valid), 64'd0);
    wait_cyc(25);
    check("valid_first", 64'(res_valid), 64'd1);
    check("data_first", 64'(res_data), 64'd24);
    wait_cyc(44);
    check("bp_valid", 64'(res_valid), 64'd1);
    check("bp_data", 64'(res_data), 64'd24);
    check("bp_din", 64'(din), 64'd2);
    check("bp_tags", 64'({res_slope, res_capa, res_pin, res_rise}), 64'd0);
    res_ready = 1'b1;
    wait_cyc(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5000, "sweep1_done");
    check("done_busy_low", 64'(busy), 64'd0);
    repeat (3) tick();
    check("sweep1_count", 64'(n_res - base), 64'(TOTAL));
    check("sweep1_first_tag", 64'(tag_log[base[9:0]]), 64'h00);
    check("sweep1_last_tag", 64'(tag_log[10'(n_res - 1)]), 64'hDB);
    check("sweep1_done_once", 64'(n_done - dbase), 64'd1);

    // Random backpressure, random data, random start pulses (some land while busy or in DONE).
    use_rand   = 1'b1;
    rand_ready = 1'b1;
    base       = n_res;
    rand_start = 1'b1;
    wait_done(8000, "sweep2_done");
    rand_start = 1'b0;
    start      = 1'b0;
    tick();
    check("sweep2_count", 64'(n_res - base), 64'(TOTAL));

    // Asynchronous reset while driving a falling edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (!(din != 2'b11 && !res_valid) && g < 4000) begin
      tick();
      g++;
    end
    check("reach_drive", 64'(din != 2'b11), 64'd1);
    #2 nrst = 1'b0;
    #1;
    check("arst_din", 64'(din), 64'd3);
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_idx", 64'({slope_idx, capa_idx}), 64'd0);
    tick();
    tick();
    nrst = 1'b1;
    repeat (5) tick();

`ifdef SWEEP_ABORT_EN
    // Abort while settling at slope 3, then restart from the beginning.
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (!(m_active && m_idx == 3 * NC * NP * 2 && cyc < m_valid_at - T) && g < 8000) begin
      tick();
      g++;
    end
    check("reach_slope3_settle", 64'(slope_idx), 64'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done", 64'(done), 64'd1);
    check("abort_din", 64'(din), 64'd3);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_idx", 64'({slope_idx, capa_idx}), 64'd0);
    base = n_res;
    repeat (30) tick();
    check("abort_no_results", 64'(n_res - base), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (n_res == base && g < 500) begin
      tick();
      g++;
    end
    tick();
    check("restart_first_tag", 64'(tag_log[base[9:0]]), 64'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
